bcd_digit_accumulator: RTL

- Downstream stage of the single-digit BCD decoder.
- Consumes a serial stream of BCD digits, most-significant digit first, one digit per accepted transfer.
- Accumulates the multi-digit decimal number into one unsigned binary word.
- Emits the word with a validity/error flag over a valid/ready handshake to the next arithmetic stage.

---
 rtl/bcd_digit_accumulator_if.sv | 32 +++
 rtl/bcd_digit_accumulator.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bcd_digit_accumulator_if.sv
// Handshake bundle for the BCD digit accumulator.
//   Upstream side  : in_valid / in_ready / in_digit / in_last  (one BCD digit per transfer)
//   Downstream side: out_valid / out_ready / out_binary / out_error / out_count
// The slave modport is the accumulator's view; master is the view of whoever
// feeds digits and consumes results.
interface bcd_digit_accumulator_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 2);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] out_binary;
  logic             out_error;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_binary, out_error, out_count
  );

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_binary, out_error, out_count
  );
endinterface

// File: rtl/bcd_digit_accumulator.sv
// BCD digit accumulator.
// Takes a serial stream of BCD digits (MSD first) and folds each frame into an
// unsigned binary word: acc = acc*10 + digit. The frame ends on in_last; the
// result, an error flag (bad digit or too many digits) and the saturating digit
// count are then presented on a valid/ready output and held until taken.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset; drops any partial frame or pending result
//   bus  - bcd_digit_accumulator_if.slave (digit input and result output handshakes)
//
// Two states: ACCUM accepts digits (in_ready=1), HOLD presents a result
// (out_valid=1). The input is blocked in HOLD, so one frame costs at least
// digits+1 cycles.
module bcd_digit_accumulator #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic clk,
  input  logic rst,
  bcd_digit_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 2);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(NUM_DIGITS + 1);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Registered outputs
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [BIN_W-1:0] out_binary_q, out_binary_d;
  logic             out_error_q, out_error_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  // Effect of the digit currently on the input
  logic             in_fire, out_fire;
  logic             digit_ok, room;
  logic [BIN_W-1:0] acc_step, acc_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             err_nx;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  assign digit_ok = (bus.in_digit <= 4'd9);
  assign room     = (cnt_q < CNT_LIM);

  // acc*10 as shift-add; truncation to BIN_W cannot lose bits for a legal
  // frame because BIN_W is sized to hold 10^NUM_DIGITS-1.
  assign acc_step = (acc_q << 3) + (acc_q << 1) + BIN_W'(bus.in_digit);

  always_comb begin
    acc_nx = acc_q;
    if (digit_ok && room) acc_nx = acc_step;
    // Error is sticky across the frame
    err_nx = err_q | ~digit_ok | ~room;
    cnt_nx = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_binary_d = out_binary_q;
    out_error_d  = out_error_q;
    out_count_d  = out_count_q;

    case (state_q)
      ACCUM: begin
        if (in_fire) begin
          if (bus.in_last) begin
            // Latch the result including this digit, and restart the
            // accumulator so the next frame starts clean after HOLD.
            out_binary_d = err_nx ? '0 : acc_nx;
            out_error_d  = err_nx;
            out_count_d  = cnt_nx;
            acc_d        = '0;
            cnt_d        = '0;
            err_d        = 1'b0;
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
            state_d      = HOLD;
          end else begin
            acc_d = acc_nx;
            cnt_d = cnt_nx;
            err_d = err_nx;
          end
        end
      end
      HOLD: begin
        // Output fields keep their values after the transfer; only the
        // handshake flags change.
        if (out_fire) begin
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d     = ACCUM;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_binary_q <= '0;
      out_error_q  <= 1'b0;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_binary_q <= out_binary_d;
      out_error_q  <= out_error_d;
      out_count_q  <= out_count_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_binary = out_binary_q;
  assign bus.out_error  = out_error_q;
  assign bus.out_count  = out_count_q;

endmodule
